// File: rtl/mux_lut_array_pkg.sv
// Shared types and helpers for the programmable LUT array.
// Holds the FSM state encoding and the truth-table depth function.
package mux_lut_pkg;

    typedef enum logic {RUN, LOAD} lut_state_t;

    function automatic int tbl_depth(int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/mux_lut_array_mux_tree.sv
// One programmable K-input gate: a 2**K:1 mux tree over its truth table.
// The tree is a heap of 2:1 muxes; the leaves are the table bits, node 0 is the result.
module mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

module mux_tree
    import mux_lut_pkg::*;
#(
    parameter int K = 2
) (
    input  logic [tbl_depth(K)-1:0] tbl,
    input  logic [K-1:0]            sel,
    output logic                    y
);

    localparam int T = tbl_depth(K);

    logic [2*T-2:0] node;

    for (genvar i = 0; i < T; i++) begin : g_leaf
        assign node[T-1+i] = tbl[i];
    end

    // Depth d from the root is selected by operand bit K-1-d, so the leaf level uses bit 0.
    for (genvar d = 0; d < K; d++) begin : g_lvl
        for (genvar i = 0; i < (1 << d); i++) begin : g_node
            mux2 u_mux (
                .a (node[2*((1 << d) - 1 + i) + 1]),
                .b (node[2*((1 << d) - 1 + i) + 2]),
                .s (sel[K-1-d]),
                .y (node[(1 << d) - 1 + i])
            );
        end
    end

    assign y = node[0];

endmodule

// File: rtl/mux_lut_array.sv
// CH independent run-time programmable K-input gates behind a valid/ready output register.
// Truth tables stream in serially to a shadow copy and commit to the active tables at once.
module mux_lut_array
    import mux_lut_pkg::*;
#(
    parameter int                      K          = 2,
    parameter int                      CH         = 4,
    parameter logic [tbl_depth(K)-1:0] INIT_TABLE = 4'b0101
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH*K-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH-1:0]   out_data,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic            cfg_bit,
    output logic            cfg_busy
);

    localparam int T     = tbl_depth(K);
    localparam int NBITS = CH * T;
    localparam int IDX_W = $clog2(NBITS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);

    lut_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [NBITS-1:0] shadow;
    logic [NBITS-1:0] shadow_nxt;
    logic [NBITS-1:0] active;
    logic [CH-1:0]    lut_y;
    logic             cfg_fire;
    logic             load_bit;
    logic             load_done;
    logic             in_fire;

    assign cfg_ready = (state == LOAD);
    assign cfg_busy  = (state == LOAD);
    assign cfg_fire  = cfg_valid && cfg_ready;
    // A restart in the same cycle as a data bit discards that bit as well.
    assign load_bit  = cfg_fire && !cfg_start;
    assign load_done = load_bit && (cnt == LAST_IDX);

    always_comb begin
        shadow_nxt = shadow;
        if (load_bit) begin
            shadow_nxt[cnt[IDX_W-1:0]] = cfg_bit;
        end
    end

    always_ff @(posedge clk) begin
        shadow <= shadow_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            cnt    <= '0;
            active <= {CH{INIT_TABLE}};
        end else begin
            case (state)
                RUN: begin
                    if (cfg_start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        cnt <= '0;
                    end else if (load_done) begin
                        active <= shadow_nxt;
                        cnt    <= '0;
                        state  <= RUN;
                    end else if (load_bit) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        mux_tree #(.K(K)) u_tree (
            .tbl (active[c*T +: T]),
            .sel (in_data[c*K +: K]),
            .y   (lut_y[c])
        );
    end

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= lut_y;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_lut_array.sv
// Directed bench for mux_lut_array (K=2, CH=4) with an output scoreboard.
// Expected results come from a bench-side truth-table model captured at accept time.
module tb_mux_lut_array;

    localparam int K  = 2;
    localparam int CH = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [CH*K-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [CH-1:0]   out_data;
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_ready;
    logic            cfg_bit;
    logic            cfg_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_out    = 0;
    int cyc      = 0;

    logic [15:0] tbl_m;
    logic [3:0]  sb[$];

    mux_lut_array #(.K(K), .CH(CH), .INIT_TABLE(4'b0101)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] model(input logic [15:0] tbl, input logic [7:0] d);
        logic [3:0] r;
        for (int c = 0; c < CH; c++) begin
            r[c] = tbl[c*4 + int'(d[c*2 +: 2])];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on input handshake, pop on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'(sb.size()), 1);
                end else begin
                    check("out_data", 32'(out_data), 32'(sb.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                sb.push_back(model(tbl_m, in_data));
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 50) begin
                check("send_ready", 32'(in_ready), 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_pulse();
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic cfg_bits(input logic [15:0] bits, input int n, input bit chk_in);
        int t;
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = bits[i];
            t         = 0;
            forever begin
                @(negedge clk);
                if (chk_in) check("in_ready_load", 32'(in_ready), 0);
                if (cfg_ready) break;
                t++;
                if (t > 50) begin
                    check("cfg_ready", 32'(cfg_ready), 1);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        out_ready = 1'b1;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("sb_drained", 32'(sb.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int out0;
        int cyc0;
        logic [3:0] exp1;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        tbl_m     = 16'h5555;

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_cfg_busy", 32'(cfg_busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_cfg_ready", 32'(cfg_ready), 0);
        @(posedge clk); #1;

        // 1: reset tables invert bit 0 of every operand
        send(8'h00);
        @(negedge clk);
        check("init_0000", 32'(out_data), 32'hF);
        @(posedge clk); #1;
        send(8'h55);
        @(negedge clk);
        check("init_5555", 32'(out_data), 32'h0);
        @(posedge clk); #1;
        send(8'hAA);
        send(8'h1B);
        drain();

        // 2: AND on every channel; inputs blocked for the whole load
        cfg_pulse();
        check("load_busy", 32'(cfg_busy), 1);
        cfg_bits(16'h8888, 16, 1'b1);
        tbl_m = 16'h8888;
        check("and_busy_done", 32'(cfg_busy), 0);
        send({2'b11, 2'b10, 2'b01, 2'b11});
        @(negedge clk);
        check("and_result", 32'(out_data), 32'b1001);
        @(posedge clk); #1;
        send(8'hFF);
        send(8'h00);
        drain();

        // 3: output stall with input held valid
        acc0      = n_acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h7D;
        exp1      = model(tbl_m, 8'h7D);
        @(negedge clk);
        check("stall_first_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_data = 8'hF3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_out_data", 32'(out_data), 32'(exp1));
            @(posedge clk); #1;
        end
        check("stall_one_accept", 32'(n_acc - acc0), 1);
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        check("stall_no_loss", 32'(n_acc - acc0), 2);

        // 4: restart after 7 bits, then restart coinciding with the final bit
        cfg_pulse();
        cfg_bits(16'hFFFF, 7, 1'b0);
        cfg_pulse();
        cfg_bits(16'h6666, 15, 1'b0);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b0;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_start = 1'b0;
        @(negedge clk);
        check("restart_wins_busy", 32'(cfg_busy), 1);
        @(posedge clk); #1;
        cfg_bits(16'h6666, 16, 1'b0);
        tbl_m = 16'h6666;
        check("xor_busy_done", 32'(cfg_busy), 0);
        send(8'b00_01_10_11);
        @(negedge clk);
        check("xor_result", 32'(out_data), 32'b0110);
        @(posedge clk); #1;
        send(8'hE4);
        send(8'h99);
        drain();

        // 5: reset in the middle of a load
        cfg_pulse();
        cfg_bits(16'h8888, 10, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midload_out_valid", 32'(out_valid), 0);
        check("midload_busy", 32'(cfg_busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tbl_m = 16'h5555;
        @(negedge clk);
        check("midload_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        send(8'h00);
        @(negedge clk);
        check("midload_inv", 32'(out_data), 32'hF);
        @(posedge clk); #1;
        send(8'h1B);
        drain();

        // 6: mixed tables, 100 back-to-back random operands
        cfg_pulse();
        cfg_bits(16'hC3A5, 16, 1'b0);
        tbl_m = 16'hC3A5;
        out0  = n_out;
        cyc0  = cyc;
        for (int i = 0; i < 100; i++) begin
            send(8'($urandom_range(0, 255)));
        end
        check("throughput_cycles", 32'(cyc - cyc0), 100);
        drain();
        check("random_out_count", 32'(n_out - out0), 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
